twp_master: RTL

Initiator end of the two-wire protocol (TWP): accepts single-word register write/read requests from a local host port, serialises them onto SDA, and for reads hands SDA over to the target for turnaround, then deserialises the 16-bit response. It sits between the system controller and any TWP register-file target on the same SDA line, and is the counterpart of the team's TWP target block.

---
 rtl/twp_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/twp_master.sv
// twp_master: initiator end of the two-wire protocol (TWP).
// Serialises single-word register writes/reads from the host port onto SDA,
// hands the line to the target for read turnaround, then deserialises the
// 16-bit response. Optional turnaround timeout: TWP_MASTER_TIMEOUT_EN.
module twp_master #(
    parameter int TAR_TIMEOUT = 8,
    parameter int IDLE_GAP    = 2
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire         SDA,
    output logic        SCL,
    input  logic        host_req,
    input  logic        host_cmd,
    input  logic [7:0]  host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_rdy,
    output logic        host_done,
    output logic [15:0] host_rdata,
    output logic        host_err
);

    // One counter covers both the turnaround wait and the GAP, so size it for the larger.
    localparam int CMAX = (TAR_TIMEOUT > IDLE_GAP) ? TAR_TIMEOUT : IDLE_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_ADDR, S_WDATA, S_TAR_WAIT, S_RDATA, S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     bit_q, bit_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cmd_q, cmd_d;
    logic [7:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    shift_q, shift_d;
    logic [15:0]    rdata_q, rdata_d;
    logic           sda_q, sda_d;
    logic           oe_q, oe_d;
    logic           scl_q, scl_d;
    logic           rdy_q, rdy_d;
    logic           done_q, done_d;
`ifdef TWP_MASTER_TIMEOUT_EN
    logic           err_q, err_d;
`endif

    // The line is only ever driven from registers; released reads as 1 via the pull-up.
    assign SDA        = oe_q ? sda_q : 1'bz;
    assign SCL        = scl_q;
    assign host_rdy   = rdy_q;
    assign host_done  = done_q;
    assign host_rdata = rdata_q;
`ifdef TWP_MASTER_TIMEOUT_EN
    assign host_err   = err_q;
`else
    assign host_err   = 1'b0;
`endif

    // Next-state logic: sequencing, request latching, turnaround and deserialisation.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
`ifdef TWP_MASTER_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    cmd_d   = host_cmd;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
`ifdef TWP_MASTER_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_START;
                end
            end
            S_START: state_d = S_CMD;
            S_CMD: begin
                bit_d   = 4'd0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                if (bit_q == 4'd7) begin
                    bit_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = cmd_q ? S_WDATA : S_TAR_WAIT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WDATA: begin
                if (bit_q == 4'd15) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_TAR_WAIT: begin
                // Only a clean 0 is the marker; X/Z or the pulled-up 1 keeps waiting.
                if (SDA == 1'b0) begin
                    bit_d   = 4'd0;
                    state_d = S_RDATA;
                end
`ifdef TWP_MASTER_TIMEOUT_EN
                else if (cnt_q == CW'(TAR_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_RDATA: begin
                // LSB arrives first, so shift right and the first bit lands in [0].
                shift_d = {SDA, shift_q[15:1]};
                if (bit_q == 4'd15) begin
                    rdata_d = shift_d;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(IDLE_GAP - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line outputs decoded from the upcoming state so they are registered alongside it.
    always_comb begin
        sda_d = 1'b1;
        oe_d  = 1'b1;
        scl_d = 1'b0;
        rdy_d = 1'b0;
        case (state_d)
            S_IDLE:     rdy_d = 1'b1;
            S_START:    begin sda_d = 1'b0;               scl_d = 1'b1; end
            S_CMD:      begin sda_d = cmd_q;              scl_d = 1'b1; end
            S_ADDR:     begin sda_d = addr_q[bit_d[2:0]]; scl_d = 1'b1; end
            S_WDATA:    begin sda_d = wdata_q[bit_d];     scl_d = 1'b1; end
            S_TAR_WAIT: begin oe_d = 1'b0;                scl_d = 1'b1; end
            S_RDATA:    begin oe_d = 1'b0;                scl_d = 1'b1; end
            S_GAP:      oe_d = cmd_q;   // reads leave the line to the target's trailing 1
            default:    ;
        endcase
    end

    // State and output registers with synchronous reset (aborts any transaction).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            sda_q   <= 1'b1;
            oe_q    <= 1'b1;
            scl_q   <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef TWP_MASTER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            scl_q   <= scl_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
`ifdef TWP_MASTER_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule
